// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin slot arbiter and broadcast mux for the 8-cycle snooping bus.
// Optional: define BUSARB_NACK_RETRY_EN to re-grant a nacked owner ahead of the scan.
module bus_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_cmd,
    input  logic [5*NREQ-1:0]    req_tag,
    input  logic [26*NREQ-1:0]   req_addr,
    input  logic [64*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      nack_in,
    input  logic [NREQ-1:0]      hit_in,
    output logic [NREQ-1:0]      grant,
    output logic [2:0]           bus_cycle,
    output logic                 bus_valid,
    output logic [2:0]           bus_cmd,
    output logic [4:0]           bus_tag,
    output logic [25:0]          bus_addr,
    output logic [63:0]          bus_data,
    output logic                 bus_nack,
    output logic                 bus_hit
);
    logic [2:0]        cyc_q, cyc_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              nack_seen_q, nack_seen_d;
    logic [2*NREQ-1:0] rot;
    logic [IDXW:0]     win, nxt;
    logic              found, do_retry, slot_end;

    // Reduce an index below 2*NREQ back into 0..NREQ-1 (works for non-power-of-2 NREQ).
    function automatic logic [IDXW:0] wrap(input logic [IDXW:0] v);
        return v >= (IDXW+1)'(NREQ) ? v - (IDXW+1)'(NREQ) : v;
    endfunction

    assign slot_end  = cyc_q == 3'd7;
    assign grant     = grant_q;
    assign bus_cycle = cyc_q;
    assign bus_valid = |grant_q;
    assign bus_nack  = |nack_in;
    assign bus_hit   = |hit_in;

`ifdef BUSARB_NACK_RETRY_EN
    logic [1:0] retry_q, retry_d;
    assign do_retry = nack_seen_q && (|(req & grant_q)) && retry_q != 2'd3;
    // Count consecutive retries of the current owner; any normal arbitration clears it.
    always_comb retry_d = slot_end ? (do_retry ? retry_q + 2'd1 : 2'd0) : retry_q;
    // Retry counter register.
    always_ff @(posedge clk or posedge rst)
        if (rst) retry_q <= 2'd0;
        else     retry_q <= retry_d;
`else
    assign do_retry = 1'b0;
`endif

    // Rotate requests so bit k is requester (ptr+k) mod NREQ; lowest set bit wins.
    always_comb begin
        rot = {req, req} >> ptr_q;
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) win = wrap({1'b0, ptr_q} + (IDXW+1)'(k));
        found = |req;
        nxt = wrap(win + (IDXW+1)'(1));
    end

    // Beat counter, slot-boundary arbitration and nack tracking.
    always_comb begin
        cyc_d = cyc_q + 3'd1;
        grant_d = grant_q;
        ptr_d = ptr_q;
        nack_seen_d = nack_seen_q | (bus_valid & bus_nack);
        if (slot_end) begin
            nack_seen_d = 1'b0;
            if (!do_retry) begin
                grant_d = found ? NREQ'(1) << win : '0;
                ptr_d = found ? nxt[IDXW-1:0] : ptr_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cyc_q <= 3'd0;
            grant_q <= '0;
            ptr_q <= '0;
            nack_seen_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            nack_seen_q <= nack_seen_d;
        end

    // Broadcast mux: one-hot grant selects the owner's fields, zero when idle.
    always_comb begin
        bus_cmd = '0;
        bus_tag = '0;
        bus_addr = '0;
        bus_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant_q[i]) begin
                bus_cmd = bus_cmd | req_cmd[3*i +: 3];
                bus_tag = bus_tag | req_tag[5*i +: 5];
                bus_addr = bus_addr | req_addr[26*i +: 26];
                bus_data = bus_data | req_data[64*i +: 64];
            end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, corner sequences and randomized model check for bus_arbiter.
module tb_bus_arbiter;
    localparam int NREQ = 4;
`ifdef BUSARB_NACK_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] nk;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req = '0, nack_in = '0, hit_in = '0;
    logic [2:0]  cmd_a  [NREQ];
    logic [4:0]  tag_a  [NREQ];
    logic [25:0] addr_a [NREQ];
    logic [63:0] data_a [NREQ];
    logic [3*NREQ-1:0]  req_cmd;
    logic [5*NREQ-1:0]  req_tag;
    logic [26*NREQ-1:0] req_addr;
    logic [64*NREQ-1:0] req_data;
    logic [NREQ-1:0] grant;
    logic [2:0] bus_cycle, bus_cmd;
    logic bus_valid, bus_nack, bus_hit;
    logic [4:0] bus_tag;
    logic [25:0] bus_addr;
    logic [63:0] bus_data;

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < NREQ; i++) begin
            req_cmd[3*i +: 3] = cmd_a[i];
            req_tag[5*i +: 5] = tag_a[i];
            req_addr[26*i +: 26] = addr_a[i];
            req_data[64*i +: 64] = data_a[i];
        end

    bus_arbiter #(.NREQ(NREQ), .IDXW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_tag(req_tag),
        .req_addr(req_addr), .req_data(req_data), .nack_in(nack_in), .hit_in(hit_in),
        .grant(grant), .bus_cycle(bus_cycle), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
        .bus_tag(bus_tag), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_nack(bus_nack), .bus_hit(bus_hit)
    );

    int checks = 0, errors = 0;
    int m_cyc = 0, m_owner = -1, m_ptr = 0, m_retry = 0;
    bit m_nack = 0, rand_mode = 0, beat_mode = 0;
    vec_t tab [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] m_grant();
        return m_owner < 0 ? '0 : NREQ'(1) << m_owner;
    endfunction

    task automatic m_reset();
        m_cyc = 0; m_owner = -1; m_ptr = 0; m_retry = 0; m_nack = 0;
    endtask

    // Reference: what happens to the bus at one clock edge.
    task automatic model_edge();
        if (m_cyc == 7) begin
            if (RETRY && m_nack && m_owner >= 0 && req[m_owner] && m_retry < 3) m_retry++;
            else begin
                m_retry = 0;
                m_owner = -1;
                for (int k = 0; k < NREQ; k++)
                    if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
                if (m_owner >= 0) m_ptr = (m_owner + 1) % NREQ;
            end
            m_nack = 0;
        end
        m_cyc = (m_cyc + 1) % 8;
    endtask

    task automatic check_all();
        #1;
        chk("grant", grant, m_grant());
        chk("bus_cycle", bus_cycle, m_cyc);
        chk("bus_valid", bus_valid, m_owner >= 0);
        chk("bus_cmd", bus_cmd, m_owner >= 0 ? cmd_a[m_owner] : 0);
        chk("bus_tag", bus_tag, m_owner >= 0 ? tag_a[m_owner] : 0);
        chk("bus_addr", bus_addr, m_owner >= 0 ? addr_a[m_owner] : 0);
        chk("bus_data", bus_data, m_owner >= 0 ? data_a[m_owner] : 0);
        chk("bus_nack", bus_nack, |nack_in);
        chk("bus_hit", bus_hit, |hit_in);
        if (m_owner >= 0 && |nack_in) m_nack = 1;
    endtask

    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] nk);
        @(posedge clk);
        model_edge();
        #1;
        req = r;
        nack_in = nk;
        if (beat_mode) data_a[2] = 64'(m_cyc);
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                cmd_a[i] = 3'($urandom);
                tag_a[i] = 5'($urandom);
                addr_a[i] = 26'($urandom);
                data_a[i] = {$urandom, $urandom};
            end
            hit_in = NREQ'($urandom);
        end
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            cmd_a[i] = 3'(i + 1);
            tag_a[i] = 5'(i + 8);
            addr_a[i] = 26'(i * 26'h11111);
            data_a[i] = 64'(i * 64'h1000_0001);
        end
        tab[0]  = '{4'b1111, 4'b0000, 4'b0001};
        tab[1]  = '{4'b1111, 4'b0000, 4'b0010};
        tab[2]  = '{4'b1111, 4'b0000, 4'b0100};
        tab[3]  = '{4'b1111, 4'b0000, 4'b1000};
        tab[4]  = '{4'b0011, 4'b1000, 4'b0001};
        tab[5]  = '{4'b0011, 4'b1000, RETRY ? 4'b0001 : 4'b0010};
        tab[6]  = '{4'b0011, 4'b1000, 4'b0001};
        tab[7]  = '{4'b0011, 4'b1000, RETRY ? 4'b0001 : 4'b0010};
        tab[8]  = '{4'b0011, 4'b0000, RETRY ? 4'b0010 : 4'b0001};
        tab[9]  = '{4'b0000, 4'b0000, RETRY ? 4'b0001 : 4'b0010};
        tab[10] = '{4'b0000, 4'b0000, 4'b0000};

        // Reset state.
        #2;
        check_all();
        #1 rst = 1'b0;
        while (m_cyc != 7) cyc(4'b1111, 4'b0000);

        // Slot table: req held through the slot, nack at beat 4, grant expected in that slot.
        for (int e = 0; e < 11; e++)
            for (int c = 0; c < 8; c++) begin
                cyc(tab[e].r, c == 4 ? tab[e].nk : 4'b0000);
                if (c == 0) chk($sformatf("tab%0d_grant", e), grant, tab[e].exp);
                if (c == 4) chk($sformatf("tab%0d_nack", e), bus_nack, |tab[e].nk);
            end

        // Request rising mid-slot waits for the next cycle-7 edge.
        for (int c = 0; c < 8; c++) begin
            cyc(c >= 3 ? 4'b0010 : 4'b0000, 4'b0000);
            if (c == 3 || c == 7) chk("late_req_idle", grant, 4'b0000);
        end
        for (int c = 0; c < 8; c++) begin
            cyc(c == 7 ? 4'b0000 : 4'b0010, 4'b0000);
            if (c == 0) chk("late_req_grant", grant, 4'b0010);
        end

        // Requester 2 alone: BUSRD, tag 5, addr 0x0800000, beat k at cycle k.
        cmd_a[2] = 3'b001;
        tag_a[2] = 5'd5;
        addr_a[2] = 26'h0800000;
        for (int c = 0; c < 8; c++) cyc(c == 7 ? 4'b0100 : 4'b0000, 4'b0000);
        beat_mode = 1;
        for (int c = 0; c < 8; c++) begin
            cyc(c == 7 ? 4'b0000 : 4'b0100, 4'b0000);
            chk($sformatf("beat%0d", c), bus_data, c);
            if (c == 5) begin
                chk("r2_cmd", bus_cmd, 3'b001);
                chk("r2_tag", bus_tag, 5'd5);
                chk("r2_addr", bus_addr, 26'h0800000);
            end
        end
        beat_mode = 0;

        // Asynchronous reset in the middle of a slot owned by requester 1.
        for (int c = 0; c < 8; c++) cyc(c == 7 ? 4'b0010 : 4'b0000, 4'b0000);
        for (int c = 0; c < 3; c++) cyc(4'b0000, 4'b0000);
        chk("pre_rst_grant", grant, 4'b0010);
        #1 rst = 1'b1;
        #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_valid", bus_valid, 1'b0);
        chk("rst_cycle", bus_cycle, 3'd0);
        chk("rst_cmd", bus_cmd, 3'd0);
        m_reset();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) cyc(4'b0000, 4'b0000);
        chk("wrap_cycle", bus_cycle, 3'd0);

        // Randomized traffic against the reference model; snoop nacks only at beat 4.
        rand_mode = 1;
        for (int n = 0; n < 3000; n++)
            cyc(NREQ'($urandom), (m_cyc == 3 && $urandom_range(0, 1) == 1) ? NREQ'($urandom) : '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter and sequencer for the shared 8-cycle snooping system bus.
- Owns the free-running bus cycle counter and grants each 8-cycle slot to one requester (dramctl, caches, I/O) by round robin.
- Muxes the owner's cmd/tag/addr/data onto the broadcast bus and OR-combines snooper nack/hit responses.

Parameters:
NREQ, 4, number of bus requesters (1..8); index 0 is highest priority at reset.
IDXW, 3, width of the owner index; must satisfy 2**IDXW >= NREQ.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester bus request (level; held until granted)
req_cmd  in  3*NREQ  requester i's command at bits [3i+:3], CMD_* encodings
req_tag  in  5*NREQ  requester i's tag at bits [5i+:5]
req_addr  in  26*NREQ  requester i's line address [31:6] at bits [26i+:26]
req_data  in  64*NREQ  requester i's data beat at bits [64i+:64]
nack_in  in  NREQ  per-agent snoop nack
hit_in  in  NREQ  per-agent snoop hit
grant  out  NREQ  one-hot grant, held for the whole slot
bus_cycle  out  3  current beat within slot, 0..7
bus_valid  out  1  slot carries a transaction
bus_cmd  out  3  broadcast command
bus_tag  out  5  broadcast tag
bus_addr  out  26  broadcast line address [31:6]
bus_data  out  64  broadcast data beat
bus_nack  out  1  OR of nack_in
bus_hit  out  1  OR of hit_in

Behaviour:
- Reset (async, immediate): bus_cycle=0, grant=0, rr pointer=0, nack_seen=0. bus_valid and all bus fields read 0 while rst is high, including mid-slot.
- bus_cycle increments every clk and wraps 7->0. Slot boundary is the edge leaving cycle 7.
- Arbitration happens only on the edge where bus_cycle==7. Scan req starting at the rr pointer, ascending and wrapping mod NREQ. The first set bit wins.
  - grant <= onehot(winner); owner <= winner; pointer <= (winner+1) mod NREQ.
  - No req set: grant <= 0 and pointer unchanged.
- Grant is stable for cycles 0..7 of the new slot. req changes mid-slot have no effect until the next cycle-7 edge.
- Requester rules:
  - Must drop req on the cycle-7 edge ending its granted slot, or it is eligible again.
  - Must hold cmd/tag/addr stable for the whole slot.
  - Must present data beat k when bus_cycle==k.
- bus_valid = |grant (combinational, whole slot).
- bus_cmd/tag/addr/data: combinational mux of the owner's inputs when bus_valid, else 0. Zero-cycle latency from requester to bus.
- bus_nack = |nack_in and bus_hit = |hit_in, combinational in every cycle. Snoopers drive these at cycle 4, after sampling at cycle 3.
- nack_seen sets when bus_valid & bus_nack, and clears on the slot boundary.
- NREQ=1: grant[0] follows req sampled at cycle 7 and the pointer stays 0.
- Width rules:
  - Pointer arithmetic is done in IDXW bits and reduced mod NREQ; must be correct for non-power-of-2 NREQ.
  - Indices >= NREQ are never granted.

Optional Feature:
Macro BUSARB_NACK_RETRY_EN.
- With it: if nack_seen is set at the cycle-7 edge and the owner still asserts req, the owner is re-granted immediately, ahead of the round-robin scan, and the pointer is not advanced. At most 3 consecutive retries per owner (2-bit counter, cleared on any non-retry grant); after that, normal round robin applies.
- Without it: nacked transactions get no special treatment; the owner competes by plain round robin.

Test Plan:
- Reset mid-slot with grant=0010 -> grant, bus_valid and bus_cycle all 0 the same cycle. After release, bus_cycle counts 0..7 and wraps.
- req=1111 held, NREQ=4 -> grants over four slots are 0001, 0010, 0100, 1000, then 0001. bus_valid high for 8 cycles each.
- Requester 2 alone, cmd=BUSRD, tag=5, addr=0x0800000, beats 0..7 = k -> bus fields match in every cycle of the slot. bus_data==k at bus_cycle==k.
- req[1] rises at bus_cycle 3 while grant=0 -> no grant until the slot after the next cycle-7 edge.
- nack_in[3]=1 at cycle 4 of requester 0's slot, req=0011 -> bus_nack=1 that cycle. With the macro: next grant 0001. Without it: next grant 0010.
- Macro on, requester 0 nacked 4 slots in a row with req=0011 -> grants 0001, 0001, 0001, 0001, then 0010.
